// File: rtl/demux_pkg.sv
// Shared types and the round-robin lane picker used by the demux lane deserializer.
package demux_pkg;

   localparam int NUM_LANES = 4;

   typedef logic [1:0] lane_t;

   typedef struct packed {
      logic  found;
      lane_t lane;
   } pick_t;

   // Nearest full lane after last_grant wins; the scan runs farthest-first so the closest overwrites.
   function automatic pick_t rr_pick(input logic [NUM_LANES-1:0] full_vec, input lane_t last_grant);
      pick_t p;
      lane_t cand;
      p = '{found: 1'b0, lane: 2'd0};
      for (int k = NUM_LANES; k >= 1; k--) begin
         cand = last_grant + lane_t'(k);
         if (full_vec[cand]) begin
            p.found = 1'b1;
            p.lane  = cand;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/demux_lane_shreg.sv
// One lane's bit assembler: shift register, bit counter and word-complete flag.
module demux_lane_shreg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             capture_i,
   input  logic             bit_i,
   input  logic             drain_i,
   output logic [WIDTH-1:0] sh_o,
   output logic             full_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full_q, full_d;
   logic             accept;

   // A lane being drained counts as empty, so a same-cycle bit starts the next word.
   assign accept = capture_i && (!full_q || drain_i);

   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      full_d = full_q && !drain_i;
      if (accept) begin
         sh_d = {sh_q[WIDTH-2:0], bit_i};
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d  = '0;
            full_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
      end
   end

   assign sh_o   = sh_q;
   assign full_o = full_q;
   assign ovf_o  = capture_i && full_q && !drain_i;

endmodule

// File: rtl/demux_lane_deserializer.sv
// Assembles the four demux lane bit streams into words and emits them round-robin on valid/ready.
// Optional DESER_PARITY_EN adds out_parity, the XOR-reduce of each loaded word.
module demux_lane_deserializer
   import demux_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_vld,
   input  logic             in0,
   input  logic             in1,
   input  logic             in2,
   input  logic             in3,
   input  logic             s1,
   input  logic             s0,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_lane,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       overflow,
   input  logic             clr_ovf
`ifdef DESER_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   lane_t                 sel;
   logic [NUM_LANES-1:0]  lane_bits;
   logic [WIDTH-1:0]      sh [NUM_LANES];
   logic [NUM_LANES-1:0]  full_vec;
   logic [NUM_LANES-1:0]  ovf_set;
   logic [NUM_LANES-1:0]  drain;
   pick_t                 pick;
   logic                  load_en;
   logic                  load;

   logic [WIDTH-1:0]      out_data_q, out_data_d;
   lane_t                 out_lane_q, out_lane_d;
   logic                  out_valid_q, out_valid_d;
   lane_t                 last_grant_q, last_grant_d;
   logic [NUM_LANES-1:0]  ovf_q, ovf_d;

   assign sel       = {s1, s0};
   assign lane_bits = {in3, in2, in1, in0};

   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         demux_lane_shreg #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
         ) u_shreg (
            .clk       (clk),
            .rst       (rst),
            .capture_i (bit_vld && (sel == lane_t'(gi))),
            .bit_i     (lane_bits[gi]),
            .drain_i   (drain[gi]),
            .sh_o      (sh[gi]),
            .full_o    (full_vec[gi]),
            .ovf_o     (ovf_set[gi])
         );
      end
   endgenerate

   always_comb begin
      pick         = rr_pick(full_vec, last_grant_q);
      load_en      = !out_valid_q || out_ready;
      load         = load_en && pick.found;
      drain        = '0;
      out_data_d   = out_data_q;
      out_lane_d   = out_lane_q;
      out_valid_d  = out_valid_q;
      last_grant_d = last_grant_q;
      if (load) begin
         drain[pick.lane] = 1'b1;
         out_data_d       = sh[pick.lane];
         out_lane_d       = pick.lane;
         out_valid_d      = 1'b1;
         last_grant_d     = pick.lane;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      // A new drop in the same cycle as a clear leaves its flag set.
      ovf_d = (clr_ovf ? '0 : ovf_q) | ovf_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q   <= '0;
         out_lane_q   <= '0;
         out_valid_q  <= 1'b0;
         last_grant_q <= lane_t'(NUM_LANES - 1);
         ovf_q        <= '0;
      end else begin
         out_data_q   <= out_data_d;
         out_lane_q   <= out_lane_d;
         out_valid_q  <= out_valid_d;
         last_grant_q <= last_grant_d;
         ovf_q        <= ovf_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_lane  = out_lane_q;
   assign out_valid = out_valid_q;
   assign overflow  = ovf_q;

`ifdef DESER_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (load) begin
         parity_q <= ^sh[pick.lane];
      end
   end

   assign out_parity = parity_q;
`endif

endmodule
